// File: rtl/srl_sra_iter.sv
`default_nettype none
// ============================================================================
//  Module      : srl_sra_iter
//  Description : Multi-cycle 32-bit right shifter supporting logical (SRL) and
//                arithmetic (SRA) shifts. One binary-weighted stage (16, 8, 4,
//                2, 1) is applied per clock, so latency is a fixed 5 cycles
//                after the accepting edge, followed by a one-cycle ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_sra_iter #(
    parameter bit ARITH_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,     // synchronous, active-low
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic [31:0] result,
    output logic        busy,
    output logic        ready
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam logic [2:0] c_LAST_STAGE = 3'd4;

    logic [1:0]  r_state;
    logic [31:0] r_work;
    logic [4:0]  r_shamt;
    logic        r_fill;
    logic [2:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_busy;
    logic        r_ready;

    logic [31:0] w_stage_out;
    logic        w_accept;
    logic        w_fill_in;

    // New work may be taken whenever no shift is in flight (IDLE or DONE).
    assign w_accept  = start && (r_state != c_S_SHIFT);
    // The fill bit is frozen at acceptance so every stage uses the same sign.
    assign w_fill_in = arith && ARITH_EN && data_in[31];

    // Single stage of the shifter: the counter picks the weight and shamt bit.
    always_comb begin
        w_stage_out = r_work;
        case (r_cnt)
            3'd0: if (r_shamt[4]) w_stage_out = {{16{r_fill}}, r_work[31:16]};
            3'd1: if (r_shamt[3]) w_stage_out = {{8{r_fill}},  r_work[31:8]};
            3'd2: if (r_shamt[2]) w_stage_out = {{4{r_fill}},  r_work[31:4]};
            3'd3: if (r_shamt[1]) w_stage_out = {{2{r_fill}},  r_work[31:2]};
            3'd4: if (r_shamt[0]) w_stage_out = {r_fill,       r_work[31:1]};
            default: w_stage_out = r_work;
        endcase
    end

    // Control FSM and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= c_S_IDLE;
            r_work   <= 32'd0;
            r_shamt  <= 5'd0;
            r_fill   <= 1'b0;
            r_cnt    <= 3'd0;
            r_result <= 32'd0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                c_S_SHIFT: begin
                    r_work <= w_stage_out;
                    if (r_cnt == c_LAST_STAGE) begin
                        r_result <= w_stage_out;
                        r_busy   <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= c_S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    // IDLE and DONE share acceptance; DONE always exits after one cycle.
                    r_ready <= 1'b0;
                    if (w_accept) begin
                        r_work  <= data_in;
                        r_shamt <= shamt;
                        r_fill  <= w_fill_in;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= c_S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_S_IDLE;
                    end
                end
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign ready  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_srl_sra_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_srl_sra_iter
//  Description : Self-checking bench for srl_sra_iter. Two instances share the
//                stimulus: one with arithmetic shifts enabled, one with them
//                disabled (always logical).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_srl_sra_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;

    logic [31:0] result,   result_l;
    logic        busy,     busy_l;
    logic        ready,    ready_l;

    int checks   = 0;
    int failures = 0;
    int excl_viol = 0;
    int wide_viol = 0;
    logic ready_q = 1'b0;

    srl_sra_iter #(.ARITH_EN(1'b1)) u_dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .shamt(shamt), .arith(arith), .result(result), .busy(busy), .ready(ready)
    );

    srl_sra_iter #(.ARITH_EN(1'b0)) u_dut_l (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in),
        .shamt(shamt), .arith(arith), .result(result_l), .busy(busy_l), .ready(ready_l)
    );

    always #5 clock = ~clock;

    // Watch the handshake outputs: busy/ready exclusive, ready one cycle wide.
    always @(negedge clock) begin
        if (busy && ready) excl_viol++;
        if (ready && ready_q) wide_viol++;
        ready_q = ready;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] d, input logic [4:0] s, input logic a);
        @(negedge clock);
        start = 1'b1; data_in = d; shamt = s; arith = a;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!ready && lat < 20) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic op(input string tag, input logic [31:0] d, input logic [4:0] s,
                      input logic a, input logic [31:0] exp, input logic [31:0] exp_l);
        int lat;
        launch(d, s, a);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_ready(lat);
        check({tag, "_lat"}, lat, 32'd5);
        check({tag, "_res"}, result, exp);
        check({tag, "_res_l"}, result_l, exp_l);
        check({tag, "_busy_rdy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;

        reset = 1'b0; start = 1'b0; data_in = 32'd0; shamt = 5'd0; arith = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_result", result, 32'h0000_0000);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_ready",  {31'd0, ready}, 32'd0);
        reset = 1'b1;

        op("srl31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 32'h0000_0001);
        @(negedge clock);
        check("srl31_ready_drop", {31'd0, ready}, 32'd0);

        op("sra4",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 32'h0800_0000);
        op("srl16",  32'h1234_5678, 5'd16, 1'b0, 32'h0000_1234, 32'h0000_1234);
        op("sra16",  32'hFFFF_0000, 5'd16, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF);
        op("zero",   32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        op("sra31p", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 32'h0000_0000);
        op("sra31n", 32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);

        // Start pulse during SHIFT is ignored.
        launch(32'h1234_5678, 5'd8, 1'b0);
        @(negedge clock);
        @(negedge clock);
        start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_ready(lat);
        check("ign_lat", lat, 32'd2);
        check("ign_res", result, 32'h0012_3456);

        // Back-to-back start accepted in the ready cycle; prior result held.
        start = 1'b1; data_in = 32'h0000_00F0; shamt = 5'd4; arith = 1'b0;
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!ready && lat < 20) begin
            check("b2b_hold", result, 32'h0012_3456);
            @(negedge clock);
            lat++;
        end
        check("b2b_lat", lat, 32'd5);
        check("b2b_res", result, 32'h0000_000F);

        // Reset at E3 aborts the operation with no ready pulse.
        launch(32'hAAAA_AAAA, 5'd1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("abort_result", result, 32'h0000_0000);
        check("abort_busy",   {31'd0, busy},  32'd0);
        check("abort_ready",  {31'd0, ready}, 32'd0);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (ready) seen++;
        end
        check("abort_no_ready", seen, 32'd0);
        op("post_abort", 32'hAAAA_AAAA, 5'd1, 1'b0, 32'h5555_5555, 32'h5555_5555);

        // Random sweep against >> / >>>.
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            exp = a ? 32'($signed(d) >>> s) : (d >> s);
            launch(d, s, a);
            wait_ready(lat);
            check("rnd_lat", lat, 32'd5);
            check("rnd_res", result, exp);
            check("rnd_res_l", result_l, d >> s);
        end

        @(negedge clock);
        check("busy_ready_excl", excl_viol, 32'd0);
        check("ready_width",     wide_viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srl_sra_iter.md
Name: srl_sra_iter

Overview:
- Multi-cycle 32-bit right shifter: logical (SRL) and arithmetic (SRA).
- Right-shift counterpart of the left-shift barrel stages used by the ALU.
- Applies one binary-weighted stage per clock (16, 8, 4, 2, 1), then returns the result with a done pulse.
- Sits beside the ALU on the execute path. Control holds the pipeline while `busy` is high.

Parameters:
- ARITH_EN, 1, when 0 the `arith` input is ignored and every shift is logical.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low. Sampled on the rising edge of clock; 0 = reset.
- start, input, 1, request strobe. Accepted only when busy=0.
- data_in, input, 32, operand. Sampled on the accepting edge.
- shamt, input, 5, shift amount 0..31. Sampled on the accepting edge.
- arith, input, 1, 1 = arithmetic (sign fill), 0 = logical (zero fill). Sampled on the accepting edge.
- result, output, 32, shifted value. Held stable from the ready pulse until the next accepted start completes.
- busy, output, 1, high while an operation is in flight.
- ready, output, 1, one-cycle done pulse. result is valid in that cycle.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE, result=0, busy=0, ready=0, stage counter=0.
  - Internal operand, shamt and fill registers cleared.
  - Reset overrides everything, including reset mid-operation. No ready pulse is produced for an aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, ready=0.
  - start=1 at an edge: latch data_in into the working register, latch shamt, and latch fill = arith & ARITH_EN & data_in[31].
  - Set the stage counter to 0 and go to SHIFT; busy=1 from this edge.
  - start=0: stay in IDLE.
- SHIFT, one stage per edge:
  - Counter values 0, 1, 2, 3, 4 select weights 16, 8, 4, 2, 1, which use shamt bits 4, 3, 2, 1, 0.
  - If the selected shamt bit is 1: working register <= working register shifted right by the weight, vacated upper bits filled with fill.
  - If the selected shamt bit is 0: working register unchanged.
  - On the edge that applies weight 1: copy the final value into result and go to DONE.
- Latency:
  - Start accepted at edge E0; stages applied at E1..E5.
  - At E5: result updated, ready=1, busy=0.
  - Latency is fixed at 5 cycles for every shamt, including 0.
- DONE:
  - Lasts exactly one cycle. ready=1, busy=0.
  - start=1 in this cycle is accepted (same actions as in IDLE): next state SHIFT, busy=1, ready drops to 0. This allows back-to-back operations.
  - Otherwise go to IDLE with ready=0.
- start while busy=1 (SHIFT) is ignored. Inputs are not re-sampled; the in-flight operation is unaffected.
- Width rules:
  - All datapath registers are 32 bits; shamt is an unsigned 5-bit value.
  - The fill bit is fixed at acceptance, so SRA of a negative value stays negative for any shamt.
  - shamt=31 SRA yields 0xFFFFFFFF (negative operand) or 0x00000000 (non-negative operand).
- result changes only at a DONE transition or at reset. It is never updated during SHIFT.

Test Plan:
- Reset behaviour: assert reset=0 for 2 cycles -> result=0x00000000, busy=0, ready=0. Release reset, then start with data_in=0x80000000, shamt=31, arith=0 -> busy for 5 cycles, then ready=1 for exactly one cycle with result=0x00000001.
- Arithmetic fill: data_in=0x80000000, shamt=4, arith=1 -> result=0xF8000000. Repeat with ARITH_EN=0 -> result=0x08000000.
- Multi-stage and zero shifts:
  - 0x12345678, shamt=16, SRL -> 0x00001234.
  - 0xFFFF0000, shamt=16, SRA -> 0xFFFFFFFF.
  - 0xDEADBEEF, shamt=0 -> 0xDEADBEEF, still with 5-cycle latency.
  - 0x7FFFFFFF, shamt=31, SRA -> 0x00000000.
- Handshake: pulse start two cycles into an operation with different operands -> ignored; the original result is delivered. Assert start in the ready cycle with 0x000000F0, shamt=4 -> accepted, next ready carries 0x0000000F. The prior result is held until then.
- Reset mid-operation: start 0xAAAAAAAA, shamt=1, then reset=0 at edge E3 -> result=0, busy=0, no ready pulse. After release, a new start completes normally.
- Random sweep: 1000 random data_in/shamt/arith triples checked against a reference model (>> and >>>). Check ready is exactly one cycle wide and that busy and ready are never high together.
